// File: rtl/rv_pkg.sv
// Shared RV64I+Zba definitions: datapath width, base opcodes, immediate
// formats and the ID/EX pipeline register layout.
package rv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            regwrite;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } idex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate from an instruction
// word and sign-extends it to XLEN.
module imm_gen #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic                 [31:0]     instr,
  input  rv_pkg::imm_type_e               imm_type,
  output logic                 [XLEN-1:0] imm
);
  import rv_pkg::*;

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX register: regfile addressing, same-cycle writeback
// bypass, immediate generation, load-use stall and the registered EX operands.
module id_ex_stage #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            valid_d,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush_e,
  output logic            stall_d,
  output logic            valid_e,
  output logic [XLEN-1:0] pc_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] op1_e,
  output logic [XLEN-1:0] op2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [6:0]      opcode_e,
  output logic [2:0]      funct3_e,
  output logic [6:0]      funct7_e,
  output logic            regwrite_e,
  output logic            mem_read_e,
  output logic            mem_write_e,
  output logic            illegal_e
);
  import rv_pkg::*;

  logic [6:0]      opc_d;
  logic [4:0]      rd_d;
  imm_type_e       imm_type_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] op1_d;
  logic [XLEN-1:0] op2_d;
  logic            uses_rs1_d;
  logic            uses_rs2_d;
  logic            wr_d;
  logic            mem_read_d;
  logic            mem_write_d;
  logic            illegal_d;
  idex_t           nxt_d;
  idex_t           q_e;

  assign opc_d = instr_d[6:0];
  assign rd_d  = instr_d[11:7];
  assign a1    = instr_d[19:15];
  assign a2    = instr_d[24:20];

  always_comb begin
    imm_type_d  = IMM_NONE;
    uses_rs1_d  = 1'b1;
    uses_rs2_d  = 1'b0;
    wr_d        = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    illegal_d   = 1'b0;
    case (opc_d)
      OPC_LOAD: begin
        imm_type_d = IMM_I;
        wr_d       = 1'b1;
        mem_read_d = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        imm_type_d = IMM_I;
        wr_d       = 1'b1;
      end
      OPC_STORE: begin
        imm_type_d  = IMM_S;
        uses_rs2_d  = 1'b1;
        mem_write_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type_d = IMM_B;
        uses_rs2_d = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        uses_rs2_d = 1'b1;
        wr_d       = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type_d = IMM_U;
        uses_rs1_d = 1'b0;
        wr_d       = 1'b1;
      end
      OPC_JAL: begin
        imm_type_d = IMM_J;
        uses_rs1_d = 1'b0;
        wr_d       = 1'b1;
      end
      OPC_SYSTEM, OPC_MISC_MEM: ;
      default: illegal_d = 1'b1;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (instr_d),
    .imm_type (imm_type_d),
    .imm      (imm_d)
  );

  // The regfile write lands on the same edge as this capture, so take it directly.
  assign op1_d = (wb_we && (wb_rd != 5'd0) && (wb_rd == a1)) ? wb_data : rd1;
  assign op2_d = (wb_we && (wb_rd != 5'd0) && (wb_rd == a2)) ? wb_data : rd2;

  assign stall_d = valid_d && valid_e && mem_read_e && (rd_e != 5'd0) && !flush_e &&
                   ((uses_rs1_d && (rd_e == a1)) || (uses_rs2_d && (rd_e == a2)));

  always_comb begin
    nxt_d           = '0;
    nxt_d.valid     = 1'b1;
    nxt_d.pc        = pc_d;
    nxt_d.rs1       = a1;
    nxt_d.rs2       = a2;
    nxt_d.rd        = rd_d;
    nxt_d.op1       = op1_d;
    nxt_d.op2       = op2_d;
    nxt_d.imm       = imm_d;
    nxt_d.opcode    = opc_d;
    nxt_d.funct3    = instr_d[14:12];
    nxt_d.funct7    = instr_d[31:25];
    nxt_d.regwrite  = wr_d && (rd_d != 5'd0);
    nxt_d.mem_read  = mem_read_d;
    nxt_d.mem_write = mem_write_d;
    nxt_d.illegal   = illegal_d;
  end

  // ID/EX boundary: flush and stall both insert a bubble; flush has already masked stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_e <= '0;
    end else if (flush_e || stall_d || !valid_d) begin
      q_e <= '0;
    end else begin
      q_e <= nxt_d;
    end
  end

  assign valid_e     = q_e.valid;
  assign pc_e        = q_e.pc;
  assign rs1_e       = q_e.rs1;
  assign rs2_e       = q_e.rs2;
  assign rd_e        = q_e.rd;
  assign op1_e       = q_e.op1;
  assign op2_e       = q_e.op2;
  assign imm_e       = q_e.imm;
  assign opcode_e    = q_e.opcode;
  assign funct3_e    = q_e.funct3;
  assign funct7_e    = q_e.funct7;
  assign regwrite_e  = q_e.regwrite;
  assign mem_read_e  = q_e.mem_read;
  assign mem_write_e = q_e.mem_write;
  assign illegal_e   = q_e.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/bypass vector table plus reset,
// load-use, false-stall and flush sequences.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic [63:0] pc_d;
  logic        valid_d;
  logic [4:0]  a1, a2;
  logic [63:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush_e;
  logic        stall_d;
  logic        valid_e;
  logic [63:0] pc_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [63:0] op1_e, op2_e, imm_e;
  logic [6:0]  opcode_e;
  logic [2:0]  funct3_e;
  logic [6:0]  funct7_e;
  logic        regwrite_e, mem_read_e, mem_write_e, illegal_e;

  int nchecks = 0;
  int nerr    = 0;

  id_ex_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush_e(flush_e), .stall_d(stall_d), .valid_e(valid_e), .pc_e(pc_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .op1_e(op1_e), .op2_e(op2_e), .imm_e(imm_e),
    .opcode_e(opcode_e), .funct3_e(funct3_e), .funct7_e(funct7_e),
    .regwrite_e(regwrite_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .illegal_e(illegal_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        vd;
    logic [63:0] r1, r2;
    logic        we;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic [63:0] op1, op2, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mr, mw, il;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic [63:0] r1, input logic [63:0] r2);
    @(negedge clk);
    instr_d = ins; valid_d = v; rd1 = r1; rd2 = r2;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0; flush_e = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".valid_e"}, {63'd0, valid_e}, 64'd0);
    chk({nm, ".op1_e"}, op1_e, 64'd0);
    chk({nm, ".pc_e"}, pc_e, 64'd0);
    chk({nm, ".imm_e"}, imm_e, 64'd0);
    chk({nm, ".ctl"}, {60'd0, regwrite_e, mem_read_e, mem_write_e, illegal_e}, 64'd0);
    chk({nm, ".rd_opc"}, {52'd0, rd_e, opcode_e}, 64'd0);
  endtask

  localparam logic [31:0] ADD_7_5_6 = 32'h006283B3;
  localparam logic [31:0] LD_5_0_1  = 32'h0000B283;

  initial begin
    // instr, vd, rd1, rd2, wb_we, wb_rd, wb_data, op1, op2, imm, opcode, f3, f7, rd, rs1, rs2, rw, mr, mw, il
    vecs[0]  = '{ADD_7_5_6,    1, 64'h11, 64'h22, 1, 5'd5, 64'hDEAD, 64'hDEAD, 64'h22, 64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd5, 5'd6, 1, 0, 0, 0};
    vecs[1]  = '{ADD_7_5_6,    1, 64'h11, 64'h22, 1, 5'd0, 64'hDEAD, 64'h11, 64'h22, 64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd5, 5'd6, 1, 0, 0, 0};
    vecs[2]  = '{ADD_7_5_6,    1, 64'h11, 64'h22, 1, 5'd6, 64'hDEAD, 64'h11, 64'hDEAD, 64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd5, 5'd6, 1, 0, 0, 0};
    vecs[3]  = '{ADD_7_5_6,    1, 64'h11, 64'h22, 0, 5'd5, 64'hDEAD, 64'h11, 64'h22, 64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd5, 5'd6, 1, 0, 0, 0};
    vecs[4]  = '{32'hFE21BC23, 1, 64'h100, 64'h200, 0, 5'd0, 64'h0, 64'h100, 64'h200, 64'hFFFFFFFFFFFFFFF8, 7'h23, 3'd3, 7'h7F, 5'd24, 5'd3, 5'd2, 0, 0, 1, 0};
    vecs[5]  = '{32'h800000B7, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFF80000000, 7'h37, 3'd0, 7'h40, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0};
    vecs[6]  = '{32'hFFDFF0EF, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC, 7'h6F, 3'd7, 7'h7F, 5'd1, 5'd31, 5'd29, 1, 0, 0, 0};
    vecs[7]  = '{32'h2020C1B3, 1, 64'h5, 64'h7, 0, 5'd0, 64'h0, 64'h5, 64'h7, 64'h0, 7'h33, 3'd4, 7'h10, 5'd3, 5'd1, 5'd2, 1, 0, 0, 0};
    vecs[8]  = '{32'hFE2088E3, 1, 64'hA, 64'hB, 0, 5'd0, 64'h0, 64'hA, 64'hB, 64'hFFFFFFFFFFFFFFF0, 7'h63, 3'd0, 7'h7F, 5'd17, 5'd1, 5'd2, 0, 0, 0, 0};
    vecs[9]  = '{32'h0000007F, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1};
    vecs[10] = '{32'h0850919B, 1, 64'h30, 64'h0, 0, 5'd0, 64'h0, 64'h30, 64'h0, 64'h85, 7'h1B, 3'd1, 7'h04, 5'd3, 5'd1, 5'd5, 1, 0, 0, 0};
    vecs[11] = '{32'h00000073, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0};
    vecs[12] = '{32'h12345297, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h12345000, 7'h17, 3'd5, 7'h09, 5'd5, 5'd8, 5'd3, 1, 0, 0, 0};
    vecs[13] = '{32'h00008067, 1, 64'h77, 64'h0, 0, 5'd0, 64'h0, 64'h77, 64'h0, 64'h0, 7'h67, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 0, 0, 0, 0};
    vecs[14] = '{ADD_7_5_6,    0, 64'h11, 64'h22, 1, 5'd5, 64'hDEAD, 64'h0, 64'h0, 64'h0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0};
    vecs[15] = '{32'hFFF00093, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 1, 0, 0, 0};
    vecs[16] = '{LD_5_0_1,     1, 64'h40, 64'h0, 0, 5'd0, 64'h0, 64'h40, 64'h0, 64'h0, 7'h03, 3'd3, 7'h00, 5'd5, 5'd1, 5'd0, 1, 1, 0, 0};
    vecs[17] = '{32'h0000000F, 1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 7'h0F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0};

    rst_n = 1'b0; instr_d = '0; pc_d = '0; valid_d = 1'b0; rd1 = '0; rd2 = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    chk("reset_init.stall_d", {63'd0, stall_d}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: each vector captured on one edge with the previous E slot never a hazard.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].instr, vecs[i].vd, vecs[i].r1, vecs[i].r2);
      pc_d = 64'h1000 + 64'(4 * i);
      wb_we = vecs[i].we; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
      #1;
      chk($sformatf("v%0d.stall_d", i), {63'd0, stall_d}, 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid_e", i), {63'd0, valid_e}, {63'd0, vecs[i].vd});
      chk($sformatf("v%0d.pc_e", i), pc_e, vecs[i].vd ? 64'h1000 + 64'(4 * i) : 64'd0);
      chk($sformatf("v%0d.op1_e", i), op1_e, vecs[i].op1);
      chk($sformatf("v%0d.op2_e", i), op2_e, vecs[i].op2);
      chk($sformatf("v%0d.imm_e", i), imm_e, vecs[i].imm);
      chk($sformatf("v%0d.fields", i), {49'd0, opcode_e, funct3_e, funct7_e},
          {49'd0, vecs[i].opc, vecs[i].f3, vecs[i].f7});
      chk($sformatf("v%0d.regs", i), {49'd0, rd_e, rs1_e, rs2_e},
          {49'd0, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
      chk($sformatf("v%0d.ctl", i), {60'd0, regwrite_e, mem_read_e, mem_write_e, illegal_e},
          {60'd0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].il});
    end

    // Asynchronous reset in the middle of a cycle with a live instruction in E.
    drive(ADD_7_5_6, 1'b1, 64'h55, 64'h66);
    @(posedge clk);
    #1;
    chk("rst_pre.op1_e", op1_e, 64'h55);
    chk("rst_pre.valid_e", {63'd0, valid_e}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    chk("rst_async.stall_d", {63'd0, stall_d}, 64'd0);
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: ld x5 then dependent add; one bubble, then add captured.
    drive(LD_5_0_1, 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    drive(ADD_7_5_6, 1'b1, 64'h11, 64'h22);
    #1;
    chk("lu.stall_d", {63'd0, stall_d}, 64'd1);
    chk("lu.a1a2", {54'd0, a1, a2}, {54'd0, 5'd5, 5'd6});
    @(posedge clk);
    #1;
    chk("lu.bubble_valid_e", {63'd0, valid_e}, 64'd0);
    chk("lu.bubble_regwrite_e", {63'd0, regwrite_e}, 64'd0);
    chk("lu.release_stall_d", {63'd0, stall_d}, 64'd0);
    @(posedge clk);
    #1;
    chk("lu.add_valid_e", {63'd0, valid_e}, 64'd1);
    chk("lu.add_rd_e", {59'd0, rd_e}, 64'd7);
    chk("lu.add_opcode_e", {57'd0, opcode_e}, 64'h33);

    // No false stall: lui overwrites rd, loads to x0, and rs2 use by a store.
    drive(LD_5_0_1, 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    drive(32'h000012B7, 1'b1, 64'h0, 64'h0);
    #1;
    chk("nfs.lui_stall_d", {63'd0, stall_d}, 64'd0);
    drive(32'h0000B003, 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    drive(32'h000003B3, 1'b1, 64'h0, 64'h0);
    #1;
    chk("nfs.ldx0_stall_d", {63'd0, stall_d}, 64'd0);
    drive(LD_5_0_1, 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    drive(32'h00513023, 1'b1, 64'h0, 64'h0);
    #1;
    chk("nfs.sd_stall_d", {63'd0, stall_d}, 64'd1);
    drive(32'h0, 1'b0, 64'h0, 64'h0);
    @(posedge clk);

    // Flush beats stall: no stall raised and E becomes a bubble.
    drive(LD_5_0_1, 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    drive(ADD_7_5_6, 1'b1, 64'h11, 64'h22);
    #1;
    chk("fl.pre_stall_d", {63'd0, stall_d}, 64'd1);
    flush_e = 1'b1;
    #1;
    chk("fl.stall_d", {63'd0, stall_d}, 64'd0);
    @(posedge clk);
    #1;
    chk("fl.valid_e", {63'd0, valid_e}, 64'd0);
    chk("fl.regwrite_e", {63'd0, regwrite_e}, 64'd0);
    chk("fl.mem_read_e", {63'd0, mem_read_e}, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
